vga_fetch_scheduler: RTL and testbench

VGA_FETCH_SCHEDULER -- requirements
Module: vga_fetch_scheduler

---
 rtl/vga_fetch_scheduler_if.sv | 41 ++++
 rtl/vga_fetch_scheduler.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_vga_fetch_scheduler.sv | 382 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_fetch_scheduler_if.sv
// Memory and CPU bus bundle for the VGA fetch scheduler.
// Latency: wires only, no storage.
// Backpressure: mem_req is held until mem_ack; cpu_req is held until cpu_ack.
//
// Signals:
//   mem_req/mem_we/mem_addr/mem_wdata  scheduler -> memory request
//   mem_rdata/mem_ack                  memory -> scheduler completion
//   cpu_req/cpu_we/cpu_addr/cpu_wdata  CPU -> scheduler request (level)
//   cpu_rdata/cpu_ack                  scheduler -> CPU completion
// Modports: master = scheduler side, slave = memory/CPU side.
interface vga_fetch_scheduler_if #(
  parameter int C_addr_bits = 20
);
  logic                   mem_req;
  logic                   mem_we;
  logic [C_addr_bits-1:0] mem_addr;
  logic [23:0]            mem_wdata;
  logic [23:0]            mem_rdata;
  logic                   mem_ack;

  logic                   cpu_req;
  logic                   cpu_we;
  logic [C_addr_bits-1:0] cpu_addr;
  logic [23:0]            cpu_wdata;
  logic [23:0]            cpu_rdata;
  logic                   cpu_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack
  );
endinterface

// File: rtl/vga_fetch_scheduler.sv
// Arbitrates one memory port between video line prefetch (into a pixel FIFO) and CPU accesses.
// Latency: one IDLE cycle between transactions; back-to-back video words at one per cycle.
// Backpressure: requests held until mem_ack; video stalls when the FIFO is full or the line is done.
//
// Ports:
//   clk_pixel, reset (async, active-high)
//   vga_hsync, vga_vblank, line_repeat  timing generator inputs
//   fetch_next                          pops the FIFO head pixel
//   red_byte/green_byte/blue_byte       FIFO head (0 when empty)
//   underflow, overrun                  sticky error flags
//   bus                                 memory + CPU bundle (master modport)
// Optional feature: define VGA_FETCH_DBLY_EN to let line_repeat refetch the previous line.
module vga_fetch_scheduler #(
  parameter int C_resolution_x    = 640,
  parameter int C_addr_bits       = 20,
  parameter int C_fifo_depth_log2 = 4,
  parameter int C_low_water       = 8,
  parameter int C_base_addr       = 0
) (
  input  logic                  clk_pixel,
  input  logic                  reset,
  input  logic                  vga_hsync,
  input  logic                  vga_vblank,
  input  logic                  line_repeat,
  input  logic                  fetch_next,
  output logic [7:0]            red_byte,
  output logic [7:0]            green_byte,
  output logic [7:0]            blue_byte,
  output logic                  underflow,
  output logic                  overrun,
  vga_fetch_scheduler_if.master bus
);

  localparam int C_depth = 1 << C_fifo_depth_log2;
  localparam int C_lvl_w = C_fifo_depth_log2 + 1;
  localparam int C_wl_w  = $clog2(C_resolution_x + 1);

  localparam logic [C_lvl_w-1:0]           C_lvl_full  = C_lvl_w'(C_depth);
  localparam logic [C_lvl_w-1:0]           C_lvl_low   = C_lvl_w'(C_low_water);
  localparam logic [C_lvl_w-1:0]           C_lvl_one   = C_lvl_w'(1);
  localparam logic [C_fifo_depth_log2-1:0] C_ptr_one   = C_fifo_depth_log2'(1);
  localparam logic [C_wl_w-1:0]            C_wl_line   = C_wl_w'(C_resolution_x);
  localparam logic [C_wl_w-1:0]            C_wl_one    = C_wl_w'(1);
  localparam logic [C_addr_bits-1:0]       C_addr_base = C_addr_bits'(C_base_addr);
  localparam logic [C_addr_bits-1:0]       C_addr_one  = C_addr_bits'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_VID  = 2'd1,
    S_CPU  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Timing edge detection
  logic r_hsync_d;
  logic r_vblank_d;
  logic r_vbl_pend;

  // Video address tracking
  logic [C_addr_bits-1:0] r_vid_addr;
  logic [C_addr_bits-1:0] r_line_start;
  logic [C_wl_w-1:0]      r_words_left;

  // Pixel FIFO
  logic [23:0]                  r_fifo [C_depth];
  logic [C_fifo_depth_log2-1:0] r_wr_ptr;
  logic [C_fifo_depth_log2-1:0] r_rd_ptr;
  logic [C_lvl_w-1:0]           r_level;

  logic        r_underflow;
  logic        r_overrun;
  logic [23:0] r_cpu_rdata;

  logic                   w_arm;
  logic                   w_vbl_rise;
  logic                   w_vbl_apply;
  logic                   w_push;
  logic                   w_pop;
  logic [C_lvl_w-1:0]     w_level_next;
  logic [C_wl_w-1:0]      w_words_dec;
  logic                   w_vid_elig;
  logic                   w_vid_urgent;
  logic [C_addr_bits-1:0] w_addr_inc;
  logic [C_addr_bits-1:0] w_addr_cont;
  logic [23:0]            w_head;

  // Line arming is blocked during vertical blank.
  assign w_arm      = vga_hsync & ~r_hsync_d & ~vga_vblank;
  assign w_vbl_rise = vga_vblank & ~r_vblank_d;
  // A frame restart must not move mem_addr under an outstanding video
  // request, so inside VID it waits for the ack that closes the transfer.
  assign w_vbl_apply = (w_vbl_rise | r_vbl_pend) & ((r_state != S_VID) | bus.mem_ack);

  assign w_push = (r_state == S_VID) & bus.mem_ack;
  assign w_pop  = fetch_next & (r_level != '0);

  always_comb begin
    w_level_next = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_next = r_level + C_lvl_one;
      2'b01:   w_level_next = r_level - C_lvl_one;
      default: w_level_next = r_level;
    endcase
  end

  assign w_words_dec  = r_words_left - C_wl_one;
  assign w_vid_elig   = (r_words_left != '0) && (r_level != C_lvl_full);
  assign w_vid_urgent = w_vid_elig && (r_level < C_lvl_low);
  assign w_addr_inc   = r_vid_addr + C_addr_one;
  // Address the next line begins at if nothing else intervenes this cycle.
  assign w_addr_cont  = w_push ? w_addr_inc : r_vid_addr;

`ifndef VGA_FETCH_DBLY_EN
  logic w_unused_line_repeat;
  assign w_unused_line_repeat = line_repeat;
`endif

  // ---------------------------------------------------------------- timing
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      r_hsync_d  <= 1'b0;
      r_vblank_d <= 1'b0;
      r_vbl_pend <= 1'b0;
    end else begin
      r_hsync_d  <= vga_hsync;
      r_vblank_d <= vga_vblank;
      if (w_vbl_apply) begin
        r_vbl_pend <= 1'b0;
      end else if (w_vbl_rise) begin
        r_vbl_pend <= 1'b1;
      end
    end
  end

  // ------------------------------------------------------ video addressing
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      r_vid_addr   <= C_addr_base;
      r_line_start <= C_addr_base;
    end else if (w_vbl_apply) begin
      r_vid_addr   <= C_addr_base;
      r_line_start <= C_addr_base;
    end else if (w_arm) begin
`ifdef VGA_FETCH_DBLY_EN
      if (line_repeat) begin
        // Doublescan: rewind to the start of the line just shown.
        r_vid_addr <= r_line_start;
      end else begin
        r_vid_addr   <= w_addr_cont;
        r_line_start <= w_addr_cont;
      end
`else
      r_vid_addr   <= w_addr_cont;
      r_line_start <= w_addr_cont;
`endif
    end else if (w_push) begin
      r_vid_addr <= w_addr_inc;
    end
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      r_words_left <= '0;
      r_overrun    <= 1'b0;
    end else if (w_arm) begin
      r_words_left <= C_wl_line;
      if (r_words_left != '0) begin
        r_overrun <= 1'b1;
      end
    end else if (w_push) begin
      r_words_left <= w_words_dec;
    end
  end

  // ------------------------------------------------------------ pixel FIFO
  always_ff @(posedge clk_pixel) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= bus.mem_rdata;
    end
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + C_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + C_ptr_one;
      end
      r_level <= w_level_next;
      if (fetch_next && (r_level == '0)) begin
        r_underflow <= 1'b1;
      end
    end
  end

  // Show-ahead head; an empty FIFO presents black rather than stale data.
  assign w_head = r_fifo[r_rd_ptr];

  always_comb begin
    red_byte   = 8'd0;
    green_byte = 8'd0;
    blue_byte  = 8'd0;
    if (r_level != '0) begin
      red_byte   = w_head[23:16];
      green_byte = w_head[15:8];
      blue_byte  = w_head[7:0];
    end
  end

  assign underflow = r_underflow;
  assign overrun   = r_overrun;

  // ------------------------------------------------------------------- FSM
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Bus outputs are decoded from the state so that reset drops any
  // outstanding request in the same instant it is asserted.
  always_comb begin
    w_state_next  = r_state;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = 24'd0;
    bus.cpu_ack   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_vid_urgent) begin
          w_state_next = S_VID;
        end else if (bus.cpu_req) begin
          w_state_next = S_CPU;
        end else if (w_vid_elig) begin
          w_state_next = S_VID;
        end
      end
      S_VID: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = r_vid_addr;
        if (bus.mem_ack) begin
          // Leave on line end, FIFO full, a CPU waiting once the FIFO is
          // comfortably stocked, or a deferred frame restart.
          if ((w_words_dec == '0) ||
              (w_level_next == C_lvl_full) ||
              (bus.cpu_req && (w_level_next >= C_lvl_low)) ||
              w_vbl_apply) begin
            w_state_next = S_IDLE;
          end
        end
      end
      S_CPU: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = bus.cpu_we;
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = bus.cpu_wdata;
        if (bus.mem_ack) begin
          bus.cpu_ack  = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      r_cpu_rdata <= 24'd0;
    end else if ((r_state == S_CPU) && bus.mem_ack) begin
      r_cpu_rdata <= bus.mem_rdata;
    end
  end

  assign bus.cpu_rdata = r_cpu_rdata;

endmodule

// File: tb/tb_vga_fetch_scheduler.sv
// Directed bench for vga_fetch_scheduler: reset state, line prefetch,
// FIFO refill, CPU arbitration, doublescan addressing and error flags.
module tb_vga_fetch_scheduler;

  localparam int C_AW = 20;

  logic       clk_pixel = 1'b0;
  logic       reset;
  logic       vga_hsync;
  logic       vga_vblank;
  logic       line_repeat;
  logic       fetch_next;
  logic [7:0] red_byte;
  logic [7:0] green_byte;
  logic [7:0] blue_byte;
  logic       underflow;
  logic       overrun;

  vga_fetch_scheduler_if #(.C_addr_bits(C_AW)) bus ();

  vga_fetch_scheduler #(
    .C_resolution_x   (640),
    .C_addr_bits      (C_AW),
    .C_fifo_depth_log2(4),
    .C_low_water      (8),
    .C_base_addr      (0)
  ) dut (
    .clk_pixel  (clk_pixel),
    .reset      (reset),
    .vga_hsync  (vga_hsync),
    .vga_vblank (vga_vblank),
    .line_repeat(line_repeat),
    .fetch_next (fetch_next),
    .red_byte   (red_byte),
    .green_byte (green_byte),
    .blue_byte  (blue_byte),
    .underflow  (underflow),
    .overrun    (overrun),
    .bus        (bus.master)
  );

  always #5 clk_pixel = ~clk_pixel;

  // Memory contents: a fixed function of the word address.
  function automatic logic [23:0] mem_model(input logic [C_AW-1:0] a);
    return {a[7:0] ^ 8'hA5, a[7:0], ~a[7:0]};
  endfunction

  assign bus.mem_rdata = mem_model(bus.mem_addr);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory responder: ack after ack_delay cycles of a held request.
  int ack_delay = 0;
  int ack_cnt   = 0;
  initial begin
    bus.mem_ack = 1'b0;
    forever begin
      @(posedge clk_pixel);
      #1;
      if (bus.mem_req && !reset) begin
        if (ack_cnt >= ack_delay) begin
          bus.mem_ack = 1'b1;
          ack_cnt     = 0;
        end else begin
          bus.mem_ack = 1'b0;
          ack_cnt++;
        end
      end else begin
        bus.mem_ack = 1'b0;
        ack_cnt     = 0;
      end
    end
  end

  // Transfer monitor
  int              n_vack = 0;
  int              n_cack = 0;
  int              cyc    = 0;
  logic [C_AW-1:0] last_vaddr = '0;
  logic [C_AW-1:0] q_addr [$];
  int              q_cyc  [$];
  initial begin
    forever begin
      @(negedge clk_pixel);
      cyc++;
      if (bus.mem_req && bus.mem_ack) begin
        if (bus.cpu_ack) begin
          n_cack++;
        end else begin
          n_vack++;
          last_vaddr = bus.mem_addr;
          q_addr.push_back(bus.mem_addr);
          q_cyc.push_back(cyc);
        end
      end
    end
  end

  function automatic logic [31:0] addr_at(input int i);
    if (i < q_addr.size()) return 32'(q_addr[i]);
    return 32'hFFFF_FFFF;
  endfunction

  function automatic int cyc_at(input int i);
    if (i < q_cyc.size()) return q_cyc[i];
    return -1000;
  endfunction

  task automatic pulse_hsync(input logic rep);
    @(posedge clk_pixel); #1;
    vga_hsync   = 1'b1;
    line_repeat = rep;
    @(posedge clk_pixel); #1;
    vga_hsync   = 1'b0;
    line_repeat = 1'b0;
  endtask

  task automatic pulse_vblank();
    @(posedge clk_pixel); #1;
    vga_vblank = 1'b1;
    repeat (2) @(posedge clk_pixel);
    #1;
    vga_vblank = 1'b0;
  endtask

  task automatic wait_vacks(input int target, input int budget, input string name);
    int i;
    i = 0;
    while ((n_vack < target) && (i < budget)) begin
      @(negedge clk_pixel);
      i++;
    end
    check(name, 32'(n_vack >= target), 32'd1);
  endtask

  typedef struct {
    logic [23:0]     rgb;
    logic [C_AW-1:0] refetch_addr;
    int              total_acks;
  } pix_vec_t;

  typedef struct {
    logic            we;
    logic [C_AW-1:0] addr;
    logic [23:0]     wdata;
    logic [23:0]     exp_rdata;
  } cpu_vec_t;

  pix_vec_t pix_tbl [4];
  cpu_vec_t cpu_tbl [4];

  initial begin
    int   bad;
    int   base;
    int   lat;
    int   pulses;
    logic got;
    logic seen_we;
    logic [C_AW-1:0] seen_addr;
    logic [23:0] seen_wdata;
    logic [C_AW-1:0] exp_l3;

    pix_tbl[0] = '{24'hA500FF, 20'd16, 17};
    pix_tbl[1] = '{24'hA401FE, 20'd17, 18};
    pix_tbl[2] = '{24'hA702FD, 20'd18, 19};
    pix_tbl[3] = '{24'hA603FC, 20'd19, 20};

    cpu_tbl[0] = '{1'b0, 20'h00123, 24'h111111, 24'h8623DC};
    cpu_tbl[1] = '{1'b1, 20'h00456, 24'hABCDEF, 24'hF356A9};
    cpu_tbl[2] = '{1'b0, 20'hFFFFF, 24'h222222, 24'h5AFF00};
    cpu_tbl[3] = '{1'b1, 20'h00000, 24'h000001, 24'hA500FF};

    reset         = 1'b1;
    vga_hsync     = 1'b0;
    vga_vblank    = 1'b0;
    line_repeat   = 1'b0;
    fetch_next    = 1'b0;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;

    // Reset state
    repeat (3) @(posedge clk_pixel);
    @(negedge clk_pixel);
    check("rst_mem_req",   32'(bus.mem_req),   32'd0);
    check("rst_mem_we",    32'(bus.mem_we),    32'd0);
    check("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    check("rst_cpu_ack",   32'(bus.cpu_ack),   32'd0);
    check("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
    check("rst_underflow", 32'(underflow),     32'd0);
    check("rst_overrun",   32'(overrun),       32'd0);
    check("rst_pixel",     32'({red_byte, green_byte, blue_byte}), 32'd0);

    // Initial fill: 16 contiguous words, then the request drops
    @(posedge clk_pixel); #1;
    reset = 1'b0;
    pulse_vblank();
    pulse_hsync(1'b0);
    repeat (60) @(negedge clk_pixel);
    check("fill_count", 32'(n_vack), 32'd16);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (addr_at(i) != 32'(i)) bad++;
    end
    check("fill_addr_seq", 32'(bad), 32'd0);
    check("fill_no_gaps", 32'(cyc_at(15) - cyc_at(0)), 32'd15);
    check("fill_req_drop", 32'(bus.mem_req), 32'd0);

    // Head pixel, pop, single-word refetch
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_pixel);
      check("pix_head", 32'({red_byte, green_byte, blue_byte}), 32'(pix_tbl[i].rgb));
      @(posedge clk_pixel); #1;
      fetch_next = 1'b1;
      @(posedge clk_pixel); #1;
      fetch_next = 1'b0;
      repeat (6) @(negedge clk_pixel);
      check("refetch_count", 32'(n_vack), 32'(pix_tbl[i].total_acks));
      check("refetch_addr", 32'(last_vaddr), 32'(pix_tbl[i].refetch_addr));
    end

    // Finish line 1 while streaming pixels out
    @(posedge clk_pixel); #1;
    fetch_next = 1'b1;
    wait_vacks(640, 3000, "line1_done");
    repeat (40) @(negedge clk_pixel);
    check("line1_acks", 32'(n_vack), 32'd640);
    check("line1_last_addr", 32'(last_vaddr), 32'd639);
    check("line1_req_idle", 32'(bus.mem_req), 32'd0);
    check("empty_pixel", 32'({red_byte, green_byte, blue_byte}), 32'd0);
    check("underflow_set", 32'(underflow), 32'd1);
    @(posedge clk_pixel); #1;
    fetch_next = 1'b0;
    repeat (5) @(negedge clk_pixel);
    check("underflow_sticky", 32'(underflow), 32'd1);
    check("overrun_clear", 32'(overrun), 32'd0);

    // Line 2 continues at 640
    pulse_hsync(1'b0);
    @(posedge clk_pixel); #1;
    fetch_next = 1'b1;
    wait_vacks(1280, 3000, "line2_done");
    check("line2_start", addr_at(640), 32'd640);
    check("line2_last", addr_at(1279), 32'd1279);

    // Line 3 with repeat requested
    pulse_hsync(1'b1);
    wait_vacks(1281, 50, "line3_started");
`ifdef VGA_FETCH_DBLY_EN
    exp_l3 = 20'd640;
`else
    exp_l3 = 20'd1280;
`endif
    check("line3_start", addr_at(1280), 32'(exp_l3));
    check("line3_no_overrun", 32'(overrun), 32'd0);

    // Arm again a few words before line 3 completes
    wait_vacks(1280 + 635, 2000, "line3_near_end");
    pulse_hsync(1'b0);
    @(negedge clk_pixel);
    check("overrun_set", 32'(overrun), 32'd1);

    // Reset clears the sticky flags
    @(posedge clk_pixel); #1;
    fetch_next = 1'b0;
    reset      = 1'b1;
    @(posedge clk_pixel); #1;
    reset = 1'b0;
    @(negedge clk_pixel);
    check("rst2_underflow", 32'(underflow), 32'd0);
    check("rst2_overrun",   32'(overrun),   32'd0);

    // Fill the FIFO, then CPU transactions with a 2-cycle memory wait
    pulse_vblank();
    pulse_hsync(1'b0);
    repeat (40) @(negedge clk_pixel);
    base      = n_vack;
    ack_delay = 2;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk_pixel); #1;
      bus.cpu_we    = cpu_tbl[k].we;
      bus.cpu_addr  = cpu_tbl[k].addr;
      bus.cpu_wdata = cpu_tbl[k].wdata;
      bus.cpu_req   = 1'b1;
      got = 1'b0; lat = 0; seen_we = 1'b0; seen_addr = '0; seen_wdata = '0;
      for (int c = 0; (c < 30) && !got; c++) begin
        @(negedge clk_pixel);
        if (bus.mem_req) lat++;
        if (bus.cpu_ack) begin
          got        = 1'b1;
          seen_we    = bus.mem_we;
          seen_addr  = bus.mem_addr;
          seen_wdata = bus.mem_wdata;
          bus.cpu_req = 1'b0;
        end
      end
      bus.cpu_req = 1'b0;
      check("cpu_ack_seen", 32'(got), 32'd1);
      check("cpu_latency", 32'(lat), 32'd3);
      check("cpu_mem_we", 32'(seen_we), 32'(cpu_tbl[k].we));
      check("cpu_mem_addr", 32'(seen_addr), 32'(cpu_tbl[k].addr));
      check("cpu_mem_wdata", 32'(seen_wdata), 32'(cpu_tbl[k].wdata));
      pulses = 0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk_pixel);
        if (bus.cpu_ack) pulses++;
      end
      check("cpu_ack_extra", 32'(pulses), 32'd0);
      check("cpu_rdata", 32'(bus.cpu_rdata), 32'(cpu_tbl[k].exp_rdata));
    end
    check("cpu_no_video", 32'(n_vack), 32'(base));

    // Drain to level 3 with memory stalled, then post a CPU request
    ack_delay = 1000;
    @(posedge clk_pixel); #1;
    fetch_next = 1'b1;
    repeat (13) @(posedge clk_pixel);
    #1;
    fetch_next   = 1'b0;
    base         = n_vack;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 20'h00ABC;
    bus.cpu_req  = 1'b1;
    ack_delay    = 0;
    got = 1'b0; seen_addr = '0;
    for (int c = 0; (c < 40) && !got; c++) begin
      @(negedge clk_pixel);
      if (bus.cpu_ack) begin
        got         = 1'b1;
        seen_addr   = bus.mem_addr;
        bus.cpu_req = 1'b0;
      end
    end
    bus.cpu_req = 1'b0;
    check("prio_cpu_served", 32'(got), 32'd1);
    check("prio_video_acks", 32'(n_vack - base), 32'd5);
    check("prio_cpu_addr", 32'(seen_addr), 32'h00ABC);

    // Reset during a stalled video transfer
    repeat (30) @(negedge clk_pixel);
    ack_delay = 1000;
    @(posedge clk_pixel); #1;
    fetch_next = 1'b1;
    @(posedge clk_pixel); #1;
    fetch_next = 1'b0;
    repeat (3) @(negedge clk_pixel);
    check("stall_req_held", 32'(bus.mem_req), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_req_drop", 32'(bus.mem_req), 32'd0);
    base = n_vack + n_cack;
    repeat (3) @(posedge clk_pixel);
    #1;
    reset     = 1'b0;
    ack_delay = 0;
    repeat (5) @(negedge clk_pixel);
    check("abort_no_transfer", 32'(n_vack + n_cack), 32'(base));
    check("abort_pixel_clear", 32'({red_byte, green_byte, blue_byte}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d tests run", n_tests);
    $fatal(1);
  end

endmodule
